// File: rtl/ifetch_unit_if.sv
// Fetch-unit signal bundle: instruction-memory request/response, decoder handshake
// and redirect. master = fetch unit side, slave = memory/decoder/pipeline side.
interface ifetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order fetches and
// buffers returned words for the decoder. Define IFETCH_PERF_CNT_EN for perf counters.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_flush
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] pq_head_q, pq_head_d;
    logic [PTR_W-1:0] pq_tail_q, pq_tail_d;

    // Word buffer and the PC side-queue that pairs each response with its address.
    logic [31:0] data_mem  [FIFO_DEPTH];
    logic [31:0] pc_mem    [FIFO_DEPTH];
    logic        err_mem   [FIFO_DEPTH];
    logic [31:0] pcq_mem   [FIFO_DEPTH];

    logic credit_ok;
    logic req_valid_w;
    logic req_fire;
    logic rsp_fire;
    logic keep_rsp;
    logic inst_valid_w;
    logic pop;

    always_comb begin
        credit_ok    = ({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_C;
        req_valid_w  = rst_n & ~bus.redirect_valid & credit_ok;
        req_fire     = req_valid_w & bus.imem_req_ready;
        rsp_fire     = bus.imem_rsp_valid;
        keep_rsp     = rsp_fire & ~bus.redirect_valid & (drop_q == '0);
        inst_valid_w = rst_n & (cnt_q != '0);
        pop          = inst_valid_w & bus.inst_ready & ~bus.redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            out_q     <= '0;
            cnt_q     <= '0;
            drop_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            pq_head_q <= '0;
            pq_tail_q <= '0;
        end else begin
            pc_q      <= pc_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            pq_head_q <= pq_head_d;
            pq_tail_q <= pq_tail_d;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        head_d    = head_q;
        tail_d    = tail_q;
        pq_head_d = pq_head_q;
        pq_tail_d = pq_tail_q;

        // In-flight bookkeeping runs even during a redirect: responses still come back.
        if (req_fire) begin
            pc_d      = pc_q + 32'd4;
            pq_tail_d = pq_tail_q + PTR_ONE;
        end
        if (rsp_fire) begin
            pq_head_d = pq_head_q + PTR_ONE;
        end
        unique case ({req_fire, rsp_fire})
            2'b10:   out_d = out_q + CNT_ONE;
            2'b01:   out_d = out_q - CNT_ONE;
            default: out_d = out_q;
        endcase

        if (bus.redirect_valid) begin
            pc_d   = bus.redirect_pc & ~32'h3;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            drop_d = rsp_fire ? (out_q - CNT_ONE) : out_q;
        end else begin
            if (rsp_fire && drop_q != '0) begin
                drop_d = drop_q - CNT_ONE;
            end
            if (keep_rsp) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            unique case ({keep_rsp, pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_mem[pq_tail_q] <= pc_q;
        end
        if (keep_rsp) begin
            data_mem[tail_q] <= bus.imem_rsp_data;
            pc_mem[tail_q]   <= pcq_mem[pq_head_q];
            err_mem[tail_q]  <= bus.imem_rsp_err;
        end
    end

    always_comb begin
        bus.imem_req_valid = req_valid_w;
        bus.imem_req_addr  = pc_q;
        bus.inst_valid     = inst_valid_w;
        bus.inst           = rst_n ? data_mem[head_q] : 32'h0;
        bus.inst_pc        = rst_n ? pc_mem[head_q]   : 32'h0;
        bus.inst_fault     = rst_n & err_mem[head_q];
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetched_q, stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            if (inst_valid_w && bus.inst_ready) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (!inst_valid_w) begin
                stall_q <= stall_q + 32'd1;
            end
            if (bus.redirect_valid) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
    assign perf_flush   = flush_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized memory/decoder environment
// compared cycle by cycle against a queue-based reference model.
module tb_ifetch_unit;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic clk;
    logic rst_n;
    ifetch_unit_if bus();
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

    ifetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] data; logic [31:0] pc; logic err; } ent_t;
    typedef struct packed { logic [31:0] addr; int unsigned t; } pend_t;

    ent_t        fq[$];
    pend_t       mq[$];
    logic [31:0] m_pc, exp_next;
    int          drop;
    int unsigned cyc;
    int          checks, errors;
    int unsigned exp_fetched, exp_stall, exp_flush;

    int unsigned lat;
    bit          hold_rsp, rand_rdy, rand_rsp, rand_err;
    logic [31:0] err_addr;

    bit          cap_armed;
    logic [31:0] cap_pc;
    int          first_req, first_valid;
    int          nfault;
    logic [31:0] fault_pc;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        for (int i = 0; i < 2; i++) begin
            #4;
            chk("rst_req_valid",  bus.imem_req_valid, 1'b0);
            chk("rst_inst_valid", bus.inst_valid, 1'b0);
            chk("rst_inst",       bus.inst, 32'h0);
            chk("rst_inst_pc",    bus.inst_pc, 32'h0);
            chk("rst_inst_fault", bus.inst_fault, 1'b0);
            @(posedge clk); #1;
            cyc++;
        end
        fq.delete();
        mq.delete();
        drop = 0;
        m_pc = RST_PC;
        exp_next = RST_PC;
        exp_fetched = 0;
        exp_stall = 0;
        exp_flush = 0;
        rst_n = 1'b1;
    endtask

    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic        rsp, rerr, exp_rv, pop, req_ok;
        logic [31:0] raddr;
        rsp = 1'b0;
        rerr = 1'b0;
        raddr = '0;
        bus.inst_ready     = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!hold_rsp && mq.size() != 0) begin
            if (mq[0].t + lat <= cyc && (!rand_rsp || $urandom_range(0, 2) != 0)) rsp = 1'b1;
        end
        if (rsp) begin
            raddr = mq[0].addr;
            rerr  = (raddr == err_addr) || (rand_err && $urandom_range(0, 7) == 0);
        end
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? word(raddr) : $urandom();
        bus.imem_rsp_err   = rerr;
        #4;

        exp_rv = !redir && (mq.size() + fq.size() < DEPTH);
        chk("req_valid", bus.imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("inst_valid", bus.inst_valid, fq.size() != 0);
        if (fq.size() != 0) begin
            chk("inst",       bus.inst, fq[0].data);
            chk("inst_pc",    bus.inst_pc, fq[0].pc);
            chk("inst_fault", bus.inst_fault, fq[0].err);
        end
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, exp_fetched);
        chk("perf_stall",   perf_stall, exp_stall);
        chk("perf_flush",   perf_flush, exp_flush);
`endif
        req_ok = exp_rv && bus.imem_req_ready;
        if (req_ok && first_req < 0) first_req = int'(cyc);
        if (bus.inst_valid && first_valid < 0) first_valid = int'(cyc);
        if (cap_armed && rdy && bus.inst_valid) begin
            cap_pc = bus.inst_pc;
            cap_armed = 1'b0;
        end
        if (rdy && bus.inst_valid && bus.inst_fault) begin
            nfault++;
            fault_pc = bus.inst_pc;
        end

        pop = (fq.size() != 0) && rdy;
        if (pop) begin
            exp_fetched++;
            chk("stream_pc", bus.inst_pc, exp_next);
            exp_next = exp_next + 32'd4;
        end
        if (fq.size() == 0) exp_stall++;
        if (redir) exp_flush++;

        if (redir) begin
            fq.delete();
            m_pc = rpc & ~32'h3;
            exp_next = m_pc;
            if (rsp) void'(mq.pop_front());
            drop = mq.size();
        end else begin
            if (pop) void'(fq.pop_front());
            if (rsp) begin
                if (drop > 0) drop--;
                else fq.push_back('{word(raddr), raddr, rerr});
                void'(mq.pop_front());
            end
            if (req_ok) begin
                mq.push_back('{m_pc, cyc});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        lat = 1; hold_rsp = 0; rand_rdy = 0; rand_rsp = 0; rand_err = 0;
        err_addr = 32'hFFFF_FFFF;
        cap_armed = 0; cap_pc = '0; nfault = 0; fault_pc = '0;
        first_req = -1; first_valid = -1;

        // Reset, 1-cycle memory, decoder always ready: check fetch-to-decode latency.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0);
        chk("first_latency", 32'(first_valid - first_req), 32'd2);

        // Decoder stalls for 10 cycles: buffer fills, requests stop, then drain in order.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0);
        chk("stall_req_valid",  bus.imem_req_valid, 1'b0);
        chk("stall_inst_valid", bus.inst_valid, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0);

        // Redirect with two requests in flight and no response that cycle.
        hold_rsp = 1;
        for (int i = 0; i < 10 && mq.size() < 2; i++) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h0000_2002);
        hold_rsp = 0;
        cap_armed = 1; cap_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && cap_armed; i++) cycle(1'b1, 1'b0, '0);
        chk("redir_first_pc", cap_pc, 32'h0000_2000);

        // Redirect in the same cycle as a response.
        hold_rsp = 1;
        for (int i = 0; i < 10 && mq.size() < 2; i++) cycle(1'b1, 1'b0, '0);
        hold_rsp = 0;
        cycle(1'b0, 1'b1, 32'h0000_3000);
        cap_armed = 1; cap_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && cap_armed; i++) cycle(1'b1, 1'b0, '0);
        chk("redir_rsp_first_pc", cap_pc, 32'h0000_3000);

        // Access fault on the 0x1004 response only.
        err_addr = 32'h0000_1004;
        do_reset();
        nfault = 0; fault_pc = '0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0);
        chk("fault_pc",    fault_pc, 32'h0000_1004);
        chk("fault_count", 32'(nfault), 32'd1);
        err_addr = 32'hFFFF_FFFF;

        // PC wrap from 0xFFFF_FFFC to 0.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 6 && m_pc != 32'h0; i++) cycle(1'b1, 1'b0, '0);
        chk("wrap_addr", bus.imem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);

        // Randomized traffic: memory stalls, variable latency, faults, redirects.
        rand_rdy = 1; rand_rsp = 1; rand_err = 1;
        for (int c = 0; c < 4; c++) begin
            lat = $urandom_range(1, 3);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 99) < 3)
                    cycle($urandom_range(0, 3) != 0, 1'b1, $urandom());
                else
                    cycle($urandom_range(0, 3) != 0, 1'b0, '0);
            end
        end
        rand_rdy = 0; rand_rsp = 0; rand_err = 0; lat = 1;

`ifdef IFETCH_PERF_CNT_EN
        // Five consumed instructions and one redirect.
        do_reset();
        for (int i = 0; i < 30 && exp_fetched < 5; i++) cycle(exp_fetched < 5, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_4000);
        chk("perf_fetched_5", perf_fetched, 32'd5);
        chk("perf_flush_1",   perf_flush, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
